// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its neighbours: instruction
// memory port, execute datapath handshake/flags and program-counter controls.
//   master : fetch sequencer side (drives imem_req/imem_addr/ir/exec_valid/pc_load/pc_inc)
//   slave  : system side (drives pc_value/a_value/imem_rdata/imem_ack/exec_done/alu flags)
interface fetch_sequencer_if;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;

    logic [ADDR_W-1:0] pc_value;
    logic [ADDR_W-1:0] a_value;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ack;
    logic [DATA_W-1:0] ir;
    logic              exec_valid;
    logic              exec_done;
    logic              alu_zr;
    logic              alu_ng;
    logic              pc_load;
    logic              pc_inc;

    modport master (
        input  pc_value, a_value, imem_rdata, imem_ack, exec_done, alu_zr, alu_ng,
        output imem_req, imem_addr, ir, exec_valid, pc_load, pc_inc
    );

    modport slave (
        output pc_value, a_value, imem_rdata, imem_ack, exec_done, alu_zr, alu_ng,
        input  imem_req, imem_addr, ir, exec_valid, pc_load, pc_inc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer for the 16-bit CPU. Fetches the word at
// the PC, strobes it to the datapath, waits for completion, then evaluates the
// jump condition from the ALU flags and issues exactly one PC load/inc pulse.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   run        : level-sensitive sequencing enable
//   bus        : fetch_sequencer_if.master (imem port, exec handshake, PC controls)
//   busy       : sequencer is inside an instruction (not IDLE/HALT/ERROR)
//   halted     : jump-to-self loop detected (only with halt detection built in)
//   err        : sticky fetch timeout
//
// Parameter TIMEOUT: FETCH cycles without ack before ERROR; 0 disables.
// Optional feature macro: FETCH_SEQ_HALT_DETECT_EN enables jump-to-self halt
// detection; without it halted is tied low and such loops keep running.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    fetch_sequencer_if.master bus,
    output logic              busy,
    output logic              halted,
    output logic              err
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_UPDATE,
`ifdef FETCH_SEQ_HALT_DETECT_EN
        S_HALT,
`endif
        S_ERROR
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [15:0]      ir_d;
    logic             load_d;
    logic             inc_d;
    logic             taken_c;
`ifdef FETCH_SEQ_HALT_DETECT_EN
    logic             halt_pend_q;
    logic             halt_pend_d;
    logic             self_jump_c;
`endif

    // Address is a pure pass-through so a freshly updated PC is fetched at once
    assign bus.imem_addr = bus.pc_value;

    // Jump condition, evaluated with the flags present when exec_done is seen
    assign taken_c = bus.ir[15] & ((bus.ir[2] & bus.alu_ng) |
                                   (bus.ir[1] & bus.alu_zr) |
                                   (bus.ir[0] & ~bus.alu_ng & ~bus.alu_zr));

`ifdef FETCH_SEQ_HALT_DETECT_EN
    // Taken jump whose target (A register) equals the current PC
    assign self_jump_c = taken_c & (bus.a_value == bus.pc_value);
`else
    assign halted = 1'b0;
`endif

    // Next-state, timeout counter and PC-control decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ir_d    = bus.ir;
        load_d  = 1'b0;
        inc_d   = 1'b0;
`ifdef FETCH_SEQ_HALT_DETECT_EN
        halt_pend_d = halt_pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_EXEC;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC, S_WAIT: begin
                if (bus.exec_done) begin
                    state_d = S_UPDATE;
                    inc_d   = ~taken_c;
`ifdef FETCH_SEQ_HALT_DETECT_EN
                    load_d      = taken_c & ~self_jump_c;
                    halt_pend_d = self_jump_c;
`else
                    load_d = taken_c;
`endif
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_UPDATE: begin
`ifdef FETCH_SEQ_HALT_DETECT_EN
                if (halt_pend_q)  state_d = S_HALT;
                else if (run)     state_d = S_FETCH;
                else              state_d = S_IDLE;
`else
                if (run) state_d = S_FETCH;
                else     state_d = S_IDLE;
`endif
            end
`ifdef FETCH_SEQ_HALT_DETECT_EN
            S_HALT:  state_d = S_HALT;
`endif
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // State plus registered outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bus.ir         <= '0;
            bus.imem_req   <= 1'b0;
            bus.exec_valid <= 1'b0;
            bus.pc_load    <= 1'b0;
            bus.pc_inc     <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
`ifdef FETCH_SEQ_HALT_DETECT_EN
            halt_pend_q    <= 1'b0;
            halted         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus.ir         <= ir_d;
            bus.imem_req   <= (state_d == S_FETCH);
            bus.exec_valid <= (state_d == S_EXEC);
            bus.pc_load    <= load_d;
            bus.pc_inc     <= inc_d;
            busy           <= (state_d == S_FETCH) || (state_d == S_EXEC) ||
                              (state_d == S_WAIT)  || (state_d == S_UPDATE);
            err            <= (state_d == S_ERROR);
`ifdef FETCH_SEQ_HALT_DETECT_EN
            halt_pend_q    <= halt_pend_d;
            halted         <= (state_d == S_HALT);
`endif
        end
    end
endmodule
